// File: rtl/smi_pkg.sv
// smi_pkg: byte-select state encoding and constants shared by the SMI blocks
package smi_pkg;
    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, BYTE3} byte_e;
    localparam logic [7:0] SMI_IDLE_BYTE = 8'h00;
    localparam int BYTES_PER_WORD = 4;
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input byte_e s);
        return w[{s, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/smi_tx_if.sv
// smi_tx_if: modem RX FIFO read port and SMI host-side bus of smi_tx
interface smi_tx_if;
    logic        o_rx_fifo_pull;
    logic [31:0] i_rx_fifo_pulled_data;
    logic        i_rx_fifo_empty;
    logic        i_smi_soe_se;
    logic [7:0]  o_smi_data_out;
    logic        o_smi_read_req;
    logic [7:0]  o_underflow_cnt;
    modport slave (
        output o_rx_fifo_pull, o_smi_data_out, o_smi_read_req, o_underflow_cnt,
        input  i_rx_fifo_pulled_data, i_rx_fifo_empty, i_smi_soe_se
    );
    modport master (
        input  o_rx_fifo_pull, o_smi_data_out, o_smi_read_req, o_underflow_cnt,
        output i_rx_fifo_pulled_data, i_rx_fifo_empty, i_smi_soe_se
    );
endinterface

// File: rtl/smi_strobe_sync.sv
// smi_strobe_sync: synchronises an active-low async strobe and pulses done on its rising edge
module smi_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic done
);
    logic [SYNC_STAGES:0] s;
    always_ff @(posedge clk)
        s <= rst ? '1 : {s[SYNC_STAGES-1:0], strobe_n};
    assign done = s[SYNC_STAGES-1] & ~s[SYNC_STAGES];
endmodule

// File: rtl/smi_tx.sv
// smi_tx: streams 32-bit RX FIFO words LSB-first onto the SMI bus, one byte per host read
// Underflow counter is built only when SMI_TX_UNDERFLOW_CNT_EN is defined.
module smi_tx
    import smi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     i_sys_clk,
    input  logic     i_rst,
    smi_tx_if.slave  bus
);
    logic        soe_done, adv, rel;
    logic        cur_v, cur_v_n, nxt_v, nxt_v_n, pull, pend;
    logic [31:0] cur, cur_n, nxt, nxt_n;
    logic [7:0]  dout;
    byte_e       state, state_n;

    smi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(i_sys_clk), .rst(i_rst), .strobe_n(bus.i_smi_soe_se), .done(soe_done)
    );

    // prefetched word has priority over a word arriving from the FIFO in the same cycle
    always_comb begin
        adv = soe_done & cur_v;
        rel = adv & (state == byte_e'(BYTES_PER_WORD - 1));
        state_n = adv ? byte_e'(state + 2'd1) : state;
        cur_n = cur;
        cur_v_n = cur_v & ~rel;
        nxt_n = nxt;
        nxt_v_n = nxt_v;
        if (!cur_v_n && nxt_v) begin
            cur_n = nxt;
            cur_v_n = 1'b1;
            nxt_v_n = 1'b0;
        end
        if (pend) begin
            if (!cur_v_n) begin
                cur_n = bus.i_rx_fifo_pulled_data;
                cur_v_n = 1'b1;
            end else begin
                nxt_n = bus.i_rx_fifo_pulled_data;
                nxt_v_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        cur <= cur_n;
        nxt <= nxt_n;
        if (i_rst) begin
            state <= BYTE0;
            cur_v <= 1'b0;
            nxt_v <= 1'b0;
            pull  <= 1'b0;
            pend  <= 1'b0;
            dout  <= SMI_IDLE_BYTE;
        end else begin
            state <= state_n;
            cur_v <= cur_v_n;
            nxt_v <= nxt_v_n;
            pull  <= ~nxt_v_n & ~bus.i_rx_fifo_empty & ~pull & ~pend;
            pend  <= pull;
            dout  <= cur_v_n ? sel_byte(cur_n, state_n) : SMI_IDLE_BYTE;
        end
    end

`ifdef SMI_TX_UNDERFLOW_CNT_EN
    logic [7:0] ucnt;
    always_ff @(posedge i_sys_clk)
        if (i_rst) ucnt <= 8'h00;
        else if (soe_done && !cur_v && ucnt != 8'hFF) ucnt <= ucnt + 8'd1;
    assign bus.o_underflow_cnt = ucnt;
`else
    assign bus.o_underflow_cnt = 8'h00;
`endif

    assign bus.o_rx_fifo_pull = pull;
    assign bus.o_smi_data_out = dout;
    assign bus.o_smi_read_req = cur_v;
endmodule
